// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin, whole-frame arbiter in front of the RMII transmit scheduler.
// Muxes the granted source onto tx_sof/tx_data and appends the eof marker beat.
//
// state  | meaning
// S_IDLE | no owner, tx_* quiet, waiting for any src_req
// S_SOF  | owner granted, tx_sof held until the scheduler takes byte 0
// S_DATA | streaming owner bytes, one per tx_ack
// S_EOF  | presenting the eof marker beat
module tx_frame_arbiter #(
  parameter int N         = 2,
  parameter int MAX_BYTES = 1500
) (
  input  logic           clk_50mhz_phased,
  input  logic           rst_n,
  input  logic [N-1:0]   src_req,
  input  logic [N*8-1:0] src_data,
  input  logic [N-1:0]   src_valid,
  input  logic [N-1:0]   src_last,
  output logic [N-1:0]   src_ack,
  output logic [N-1:0]   grant,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  output logic           tx_sof,
  output logic           tx_eof,
  input  logic           tx_ack,
  output logic [15:0]    frame_count,
  output logic           err_underrun,
  output logic           err_oversize
);
  localparam int          IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [10:0] LAST_CNT = 11'(MAX_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SOF, S_DATA, S_EOF} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] last_grant, grant_idx, pick_idx;
  logic [N-1:0]  pick_oh;
  logic          pick_found;
  logic [10:0]   byte_cnt;
  logic [7:0]    sel_data;
  logic          sel_valid, sel_last;
  logic          in_frame, take_byte, underrun, oversize;

  // Highest offset first so the smallest offset after last_grant wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    for (int i = N; i >= 1; i--) begin
      for (int j = 0; j < N; j++) begin
        if (src_req[j] && (j == (int'(last_grant) + i) % N)) begin
          pick_found = 1'b1;
          pick_idx   = IW'(j);
          pick_oh    = '0;
          pick_oh[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_data  = src_data[8*i +: 8];
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
      end
    end
  end

  assign in_frame  = (state == S_SOF) || (state == S_DATA);
  assign take_byte = in_frame && tx_ack && sel_valid;
  assign underrun  = in_frame && tx_ack && !sel_valid;
  // byte_cnt counts bytes already passed, so the MAX_BYTES-th byte sees MAX_BYTES-1.
  assign oversize  = (state == S_DATA) && take_byte && !sel_last && (byte_cnt == LAST_CNT);

  always_ff @(posedge clk_50mhz_phased or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pick_found) state_nxt = S_SOF;
      S_SOF, S_DATA: begin
        if (underrun || (take_byte && (sel_last || oversize))) state_nxt = S_EOF;
        else if (take_byte)                                    state_nxt = S_DATA;
      end
      S_EOF:  if (tx_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    src_ack  = '0;
    case (state)
      S_SOF, S_DATA: begin
        tx_valid = sel_valid;
        tx_data  = sel_data;
        tx_sof   = (state == S_SOF);
        if (take_byte) src_ack = grant;
      end
      S_EOF: begin
        tx_valid = 1'b1;
        tx_eof   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50mhz_phased or negedge rst_n) begin
    if (!rst_n) begin
      grant        <= '0;
      grant_idx    <= '0;
      last_grant   <= IW'(N - 1);
      byte_cnt     <= '0;
      frame_count  <= '0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      if (state == S_IDLE && pick_found) begin
        grant     <= pick_oh;
        grant_idx <= pick_idx;
        byte_cnt  <= '0;
      end
      if (take_byte) byte_cnt <= byte_cnt + 11'd1;
      if (underrun)  err_underrun <= 1'b1;
      if (oversize)  err_oversize <= 1'b1;
      if (state == S_EOF && tx_ack) begin
        grant       <= '0;
        last_grant  <= grant_idx;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: directed frames plus random traffic from three sources,
// checked beat by beat against a frame-level reference model.
module tb_tx_frame_arbiter;
  localparam int N      = 3;
  localparam int MAXB   = 100;
  localparam int FMAX   = 160;
  localparam int NO_UND = 1 << 20;

  logic           clk_50mhz_phased;
  logic           rst_n;
  logic [N-1:0]   src_req, src_valid, src_last, src_ack, grant;
  logic [N*8-1:0] src_data;
  logic           tx_valid, tx_sof, tx_eof, tx_ack;
  logic [7:0]     tx_data;
  logic [15:0]    frame_count;
  logic           err_underrun, err_oversize;

  tx_frame_arbiter #(.N(N), .MAX_BYTES(MAXB)) dut (
    .clk_50mhz_phased(clk_50mhz_phased), .rst_n(rst_n),
    .src_req(src_req), .src_data(src_data), .src_valid(src_valid), .src_last(src_last),
    .src_ack(src_ack), .grant(grant), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_ack(tx_ack), .frame_count(frame_count),
    .err_underrun(err_underrun), .err_oversize(err_oversize)
  );

  initial clk_50mhz_phased = 1'b0;
  always #10 clk_50mhz_phased = ~clk_50mhz_phased;

  // source buffers
  logic [7:0] fr_data [N][FMAX];
  int         fr_len [N];
  int         fr_ptr [N];
  int         fr_und [N];
  bit         fr_pend [N];
  int         ack_cnt [N];
  bit         drop_req, rand_on;
  int         reload_left;
  logic [N-1:0] reload_mask;
  // scheduler model
  bit         sch_busy;
  int         sch_cool;
  // reference model
  int         ref_last, ref_owner, ref_beat, ref_frames;
  bit         ref_under, ref_over;
  logic [N-1:0] served [$];
  logic [N-1:0] grant_prev;

  int n_tests, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lim(input int g);
    return (fr_len[g] < MAXB) ? fr_len[g] : MAXB;
  endfunction
  function automatic bit is_under(input int g);
    return fr_und[g] < lim(g);
  endfunction
  function automatic int n_data(input int g);
    return is_under(g) ? fr_und[g] : lim(g);
  endfunction
  function automatic int eof_beat(input int g);
    return is_under(g) ? fr_und[g] + 1 : lim(g);
  endfunction

  task automatic load_frame(input int p, input int len, input bit rnd, input int und);
    for (int k = 0; k < len; k++) fr_data[p][k] = rnd ? 8'($urandom) : 8'(k + 1);
    fr_len[p] = len; fr_ptr[p] = 0; fr_und[p] = und; fr_pend[p] = 1'b1;
  endtask

  task automatic rand_frame(input int p);
    int r, len, und;
    r   = int'($urandom_range(0, 9));
    len = (r < 6) ? int'($urandom_range(1, 12)) :
          (r < 8) ? int'($urandom_range(13, 40)) : int'($urandom_range(95, 105));
    und = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : NO_UND;
    load_frame(p, len, 1'b1, und);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      fr_pend[i] = 1'b0; fr_ptr[i] = 0; fr_len[i] = 0; fr_und[i] = NO_UND; ack_cnt[i] = 0;
    end
    sch_busy = 1'b0; sch_cool = 0;
    ref_last = N - 1; ref_owner = -1; ref_beat = 0; ref_frames = 0;
    ref_under = 1'b0; ref_over = 1'b0;
    served.delete(); grant_prev = '0;
    reload_left = 0; reload_mask = '0; rand_on = 1'b0; drop_req = 1'b0;
  endtask

  task automatic drive_src();
    bit live;
    for (int i = 0; i < N; i++) begin
      live = fr_pend[i] && (fr_ptr[i] < fr_len[i]);
      src_req[i]         = fr_pend[i] && !(drop_req && fr_ptr[i] > 0);
      src_valid[i]       = live && (fr_ptr[i] != fr_und[i]);
      src_last[i]        = live && (fr_ptr[i] == fr_len[i] - 1);
      src_data[8*i +: 8] = live ? fr_data[i][fr_ptr[i]] : 8'h00;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_tx"}, {tx_valid, tx_sof, tx_eof, tx_data}, 0);
    chk({tag, "_src_ack"}, src_ack, 0);
    chk({tag, "_frames"}, frame_count, 0);
    chk({tag, "_errs"}, {err_underrun, err_oversize}, 0);
  endtask

  task automatic check_cycle(input bit ack);
    int g;
    logic [N-1:0] eg;
    g  = ref_owner;
    eg = (g < 0) ? '0 : N'(1 << g);
    chk("grant", grant, eg);
    chk("frame_count", frame_count, 16'(ref_frames));
    chk("err_flags", {err_underrun, err_oversize}, {ref_under, ref_over});
    if (grant != '0 && grant_prev == '0) served.push_back(grant);
    grant_prev = grant;
    if (g < 0) begin
      chk("idle_tx", {tx_valid, tx_sof, tx_eof, tx_data}, 0);
      chk("idle_src_ack", src_ack, 0);
    end else begin
      chk("tx_sof", tx_sof, ref_beat == 0);
      chk("tx_eof", tx_eof, ref_beat == eof_beat(g));
      if (ref_beat == eof_beat(g))  chk("eof_beat", {tx_valid, tx_data}, 9'h100);
      else if (ref_beat < n_data(g)) chk("data_beat", {tx_valid, tx_data}, {1'b1, fr_data[g][ref_beat]});
      else                          chk("underrun_valid", tx_valid, 0);
      chk("src_ack", src_ack, (ack && ref_beat < n_data(g)) ? eg : '0);
    end
  endtask

  task automatic update(input bit ack, input logic [N-1:0] req_now, input bit idle0,
                        input logic [N-1:0] sa, input bit eof_at);
    int g, c;
    for (int i = 0; i < N; i++) if (sa[i]) begin fr_ptr[i]++; ack_cnt[i]++; end
    if (ack) begin
      sch_busy = !eof_at;
      sch_cool = eof_at ? int'($urandom_range(3, 9)) : int'($urandom_range(3, 5));
    end else if (sch_cool > 0) sch_cool--;
    g = ref_owner;
    if (!idle0 && ack) begin
      if (ref_beat == eof_beat(g)) begin
        ref_frames++; ref_last = g; ref_owner = -1; fr_pend[g] = 1'b0;
      end else begin
        if (is_under(g) && ref_beat == fr_und[g]) ref_under = 1'b1;
        if (!is_under(g) && fr_len[g] > MAXB && ref_beat == MAXB - 1) ref_over = 1'b1;
        ref_beat++;
      end
    end else if (idle0 && req_now != '0) begin
      for (int k = 1; k <= N; k++) begin
        c = (ref_last + k) % N;
        if (req_now[c]) begin ref_owner = c; break; end
      end
      ref_beat = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (!fr_pend[i]) begin
        if (reload_mask[i] && reload_left > 0) begin
          load_frame(i, int'($urandom_range(2, 8)), 1'b1, NO_UND);
          reload_left--;
        end else if (rand_on && $urandom_range(0, 5) == 0) rand_frame(i);
      end
    end
  endtask

  // one clock: drive at posedge+1, ack at +2, check at negedge, advance model after posedge
  task automatic cycle();
    bit ack_now, idle0, eof_at;
    logic [N-1:0] req_now, sa;
    drive_src();
    #1;
    ack_now = (sch_cool == 0) && (tx_sof || tx_eof || sch_busy) && ($urandom_range(0, 3) != 0);
    tx_ack  = ack_now;
    @(negedge clk_50mhz_phased);
    req_now = src_req; idle0 = (ref_owner < 0); sa = src_ack; eof_at = tx_eof;
    check_cycle(ack_now);
    @(posedge clk_50mhz_phased); #1;
    update(ack_now, req_now, idle0, sa, eof_at);
  endtask

  task automatic run_idle(input int budget);
    int  c;
    bit  busy;
    c = 0;
    do begin
      cycle(); c++;
      busy = (ref_owner >= 0);
      for (int i = 0; i < N; i++) busy |= fr_pend[i];
    end while (busy && c < budget);
    chk("run_timeout", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tx_ack = 1'b0;
    model_clear(); drive_src();
    @(posedge clk_50mhz_phased); #1;
    check_reset_vals("rst");
    @(negedge clk_50mhz_phased); rst_n = 1'b1;
    @(posedge clk_50mhz_phased); #1;
  endtask

  logic [N-1:0] exp_ord [4];

  initial begin
    int c;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; tx_ack = 1'b0;
    model_clear(); drive_src();

    // 64-byte frame on port 0
    do_reset();
    load_frame(0, 64, 1'b0, NO_UND);
    run_idle(1500);
    chk("t1_acks", ack_cnt[0], 64);
    chk("t1_frames", frame_count, 1);
    chk("t1_grant_idle", grant, 0);

    // ports 0 and 1 requesting continuously
    do_reset();
    load_frame(0, 5, 1'b1, NO_UND);
    load_frame(1, 5, 1'b1, NO_UND);
    reload_mask = 3'b011; reload_left = 2;
    run_idle(1500);
    exp_ord = '{3'b001, 3'b010, 3'b001, 3'b010};
    chk("t2_grants", served.size(), 4);
    for (int k = 0; k < 4; k++) chk("t2_order", (served.size() > k) ? served[k] : '0, exp_ord[k]);
    chk("t2_frames", frame_count, 4);

    // one-byte frame
    do_reset();
    load_frame(1, 1, 1'b0, NO_UND);
    fr_data[1][0] = 8'h5A;
    run_idle(300);
    chk("t3_acks", ack_cnt[1], 1);
    chk("t3_frames", frame_count, 1);

    // underrun on port 1 after 10 bytes, then a clean port 0 frame
    do_reset();
    load_frame(1, 20, 1'b0, 10);
    run_idle(500);
    chk("t4_acks", ack_cnt[1], 10);
    chk("t4_underrun", err_underrun, 1);
    load_frame(0, 12, 1'b1, NO_UND);
    run_idle(500);
    chk("t4_next_acks", ack_cnt[0], 12);
    chk("t4_frames", frame_count, 2);
    chk("t4_oversize", err_oversize, 0);

    // exactly MAX_BYTES is legal, 150 bytes is cut at MAX_BYTES
    do_reset();
    load_frame(0, 100, 1'b1, NO_UND);
    run_idle(1500);
    chk("t5_exact_acks", ack_cnt[0], 100);
    chk("t5_exact_oversize", err_oversize, 0);
    ack_cnt[0] = 0;
    load_frame(0, 150, 1'b1, NO_UND);
    run_idle(1500);
    chk("t5_cut_acks", ack_cnt[0], 100);
    chk("t5_oversize", err_oversize, 1);

    // reset in the middle of a frame
    do_reset();
    load_frame(1, 6, 1'b1, NO_UND);
    run_idle(500);
    ack_cnt[0] = 0;
    load_frame(0, 40, 1'b0, NO_UND);
    c = 0;
    while (ack_cnt[0] < 20 && c < 2000) begin cycle(); c++; end
    chk("t6_reached", ack_cnt[0], 20);
    #2; rst_n = 1'b0; tx_ack = 1'b0;
    #1;
    check_reset_vals("t6_midrst");
    model_clear(); drive_src();
    @(negedge clk_50mhz_phased); rst_n = 1'b1;
    @(posedge clk_50mhz_phased); #1;
    load_frame(0, 3, 1'b1, NO_UND);
    load_frame(1, 3, 1'b1, NO_UND);
    load_frame(2, 3, 1'b1, NO_UND);
    run_idle(1500);
    chk("t6_first_grant", (served.size() > 0) ? served[0] : '0, 3'b001);

    // random traffic, requests dropped after the first byte is taken
    do_reset();
    rand_on = 1'b1; drop_req = 1'b1;
    c = 0;
    while (ref_frames < 50 && c < 30000) begin cycle(); c++; end
    chk("rand_budget", c < 30000, 1);
    rand_on = 1'b0;
    run_idle(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
